mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the RAM arbiter: grant-state encoding, the
//   Enable/Disable and ZeroWord constants, and the default RAM byte-address
//   width used by the arbiter.
`timescale 1ns/1ps
package mem_arbiter_pkg;

  localparam int RAM_ADDR_BIT = 17;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IC  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Single-port RAM arbiter between the ICACHE line-fill port and the
//   MEM-stage load/store port. The grant is registered, so it changes only on
//   a clock edge. An owner keeps the grant for as long as its request stays
//   high; when it drops, the next owner is picked in the same edge. A starve
//   counter gives ICACHE priority once it has waited STARVE_LIMIT cycles.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   re_IC_i, addr_IC_i         ICACHE read request (held for a whole fill)
//   stl_IC_o                   ICACHE requesting but not granted
//   re_MEM_i, we_MEM_i         MEM-stage read / write request
//   addr_MEM_i, data_MEM_i     MEM-stage byte address / write byte
//   stl_MEM_o                  MEM stage requesting but not granted
//   ram_addr_o, ram_wr_o,
//   ram_data_o                 RAM byte address, write strobe, write byte
`timescale 1ns/1ps
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BIT     = RAM_ADDR_BIT,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re_IC_i,
  input  logic [31:0]         addr_IC_i,
  output logic                stl_IC_o,
  input  logic                re_MEM_i,
  input  logic                we_MEM_i,
  input  logic [31:0]         addr_MEM_i,
  input  logic [7:0]          data_MEM_i,
  output logic                stl_MEM_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic                ram_wr_o,
  output logic [7:0]          ram_data_o
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  arb_state_t       w_next;
  arb_state_t       w_pick;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_req_ic;
  logic             w_req_mem;
  logic             w_starve;
  logic             w_stl_ic;
  logic             w_stl_mem;
  logic             w_unused;

  assign w_req_ic  = re_IC_i;
  // A simultaneous read+write is a write; either bit makes a MEM request.
  assign w_req_mem = re_MEM_i | we_MEM_i;
  assign w_starve  = (r_starve_cnt == LIMIT);

  // Upper address bits wrap; they are intentionally dropped.
  assign w_unused = ^{addr_IC_i[31:ADDR_BIT], addr_MEM_i[31:ADDR_BIT]};

  // Arbitration rule used from IDLE and on every hand-off.
  always_comb begin
    w_pick = IDLE;
    if (w_starve && w_req_ic) w_pick = GNT_IC;
    else if (w_req_mem)       w_pick = GNT_MEM;
    else if (w_req_ic)        w_pick = GNT_IC;
  end

  // No preemption: the owner holds until its own request drops.
  always_comb begin
    w_next = w_pick;
    case (r_state)
      GNT_IC:  if (w_req_ic)  w_next = GNT_IC;
      GNT_MEM: if (w_req_mem) w_next = GNT_MEM;
      default: w_next = w_pick;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Stalls are forced low during reset, even with requests asserted.
  assign w_stl_ic  = ~rst & w_req_ic  & (r_state != GNT_IC);
  assign w_stl_mem = ~rst & w_req_mem & (r_state != GNT_MEM);
  assign stl_IC_o  = w_stl_ic;
  assign stl_MEM_o = w_stl_mem;

  // Clear on entry to GNT_IC wins over the stall increment of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_starve_cnt <= '0;
    else if (w_next == GNT_IC && r_state != GNT_IC)
      r_starve_cnt <= '0;
    else if (w_stl_ic && !w_starve)
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // RAM output mux. r_state resets asynchronously, so a reset mid-write
  // drops ram_wr_o immediately.
  always_comb begin
    ram_addr_o = ZERO_WORD[ADDR_BIT-1:0];
    ram_wr_o   = DISABLE;
    ram_data_o = ZERO_WORD[7:0];
    case (r_state)
      GNT_IC: begin
        ram_addr_o = addr_IC_i[ADDR_BIT-1:0];
      end
      GNT_MEM: begin
        ram_addr_o = addr_MEM_i[ADDR_BIT-1:0];
        ram_wr_o   = we_MEM_i ? ENABLE : DISABLE;
        ram_data_o = data_MEM_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AB = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re_IC_i = 1'b0;
  logic [31:0]   addr_IC_i = '0;
  logic          stl_IC_o;
  logic          re_MEM_i = 1'b0;
  logic          we_MEM_i = 1'b0;
  logic [31:0]   addr_MEM_i = '0;
  logic [7:0]    data_MEM_i = '0;
  logic          stl_MEM_o;
  logic [AB-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_data_o;

  mem_arbiter #(.ADDR_BIT(AB), .STARVE_LIMIT(15)) dut (
    .clk(clk), .rst(rst),
    .re_IC_i(re_IC_i), .addr_IC_i(addr_IC_i), .stl_IC_o(stl_IC_o),
    .re_MEM_i(re_MEM_i), .we_MEM_i(we_MEM_i), .addr_MEM_i(addr_MEM_i),
    .data_MEM_i(data_MEM_i), .stl_MEM_o(stl_MEM_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_data_o(ram_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          stl_ic;
    logic          stl_mem;
    logic [AB-1:0] addr;
    logic          wr;
    logic [7:0]    data;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  function automatic obs_t observe();
    obs_t o;
    o = {stl_IC_o, stl_MEM_o, ram_addr_o, ram_wr_o, ram_data_o};
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got stl_ic=%0b stl_mem=%0b addr=%h wr=%0b data=%h, want stl_ic=%0b stl_mem=%0b addr=%h wr=%0b data=%h",
                  nm, act.stl_ic, act.stl_mem, act.addr, act.wr, act.data,
                  ex.stl_ic, ex.stl_mem, ex.addr, ex.wr, ex.data);
  endtask

  task automatic chk_cnt(input string nm, input int ex);
    n_chk++;
    if (int'(dut.r_starve_cnt) == ex) n_pass++;
    else $display("FAIL %s: starve counter got %0d, want %0d", nm, int'(dut.r_starve_cnt), ex);
  endtask

  // Monitor: one expected observation per cycle, sampled mid-cycle.
  obs_t  mon_exp;
  string mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      check(mon_nm, observe(), mon_exp);
    end
  end

  task automatic set_in(input logic ric, input logic [31:0] aic, input logic rm, input logic wm,
                        input logic [31:0] am, input logic [7:0] dm);
    re_IC_i = ric; addr_IC_i = aic; re_MEM_i = rm; we_MEM_i = wm;
    addr_MEM_i = am; data_MEM_i = dm;
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic cyc(input string nm, input logic ric, input logic [31:0] aic,
                     input logic rm, input logic wm, input logic [31:0] am, input logic [7:0] dm,
                     input logic esi, input logic esm, input logic [AB-1:0] ea,
                     input logic ew, input logic [7:0] ed);
    obs_t e;
    @(posedge clk); #1;
    set_in(ric, aic, rm, wm, am, dm);
    e = {esi, esm, ea, ew, ed};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset held with requests asserted: everything stays quiet.
    cyc("rst_quiet0", 1, 32'h40, 0, 1, 32'h10, 8'hA5, 0, 0, 0, 0, 0);
    cyc("rst_quiet1", 1, 32'h40, 0, 1, 32'h10, 8'hA5, 0, 0, 0, 0, 0);
    @(negedge clk); #2;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    cyc("idle",        0, 0,      0, 0, 0, 0,         0, 0, 0, 0, 0);
    // ICACHE alone: one stall cycle, then the address appears.
    cyc("ic_req",      1, 32'h40, 0, 0, 0, 0,         1, 0, 0, 0, 0);
    cyc("ic_gnt",      1, 32'h40, 0, 0, 0, 0,         0, 0, 17'h40, 0, 0);
    cyc("ic_drop",     0, 0,      0, 0, 0, 0,         0, 0, 0, 0, 0);
    // Simultaneous: MEM wins, IC stalls until MEM drops, then hand-off.
    cyc("both_req",    1, 32'h80, 0, 1, 32'h10, 8'hA5, 1, 1, 0, 0, 0);
    cyc("mem_wr",      1, 32'h80, 0, 1, 32'h10, 8'hA5, 1, 0, 17'h10, 1, 8'hA5);
    cyc("mem_rd",      1, 32'h80, 1, 0, 32'h11, 8'h3C, 1, 0, 17'h11, 0, 8'h3C);
    cyc("mem_drop",    1, 32'h80, 0, 0, 32'h11, 8'h3C, 1, 0, 17'h11, 0, 8'h3C);
    // IC fill of 16 bytes; MEM requests throughout and is not granted.
    for (int i = 0; i < 16; i++)
      cyc("ic_fill_nopreempt", 1, 32'h80 + i, 1, 0, 32'h200, 8'h00,
          0, 1, 17'h80 + 17'(i), 0, 0);
    cyc("ic_fill_end", 0, 0,      1, 0, 32'h200, 8'h00, 0, 1, 0, 0, 0);
    // MEM holds the grant while IC waits well past the limit.
    for (int i = 0; i < 20; i++)
      cyc("ic_wait", 1, 32'h0002_0300, 1, 0, 32'h200, 8'h00, 1, 0, 17'h200, 0, 0);
    cyc("both_drop",   0, 0,      0, 0, 32'h200, 8'h00, 0, 0, 17'h200, 0, 0);
    @(negedge clk); #1;
    chk_cnt("cnt_saturated", 15);
    // From IDLE with the flag set, IC beats a simultaneous MEM request.
    // Addresses carry upper bits that must wrap away.
    cyc("starve_arb",  1, 32'h0002_0300, 0, 1, 32'hFFFE_0400, 8'h5A, 1, 1, 0, 0, 0);
    cyc("starve_ic",   1, 32'h0002_0300, 0, 1, 32'hFFFE_0400, 8'h5A, 0, 1, 17'h300, 0, 0);
    @(negedge clk); #1;
    chk_cnt("cnt_cleared", 0);
    cyc("starve_icdrop", 0, 0,    0, 1, 32'hFFFE_0400, 8'h5A, 0, 1, 0, 0, 0);
    cyc("mem_wr2",     0, 0,      1, 1, 32'hFFFE_0400, 8'h5A, 0, 0, 17'h400, 1, 8'h5A);
    // Reset in the middle of a write: outputs drop without a clock edge.
    @(negedge clk); #1;
    rst = 1'b1;
    #1 check("rst_async", observe(), '0);
    @(posedge clk); #1;
    check("rst_held", observe(), '0);
    @(negedge clk); #1;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("post_idle",   0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0);
    cyc("post_req",    0, 0, 0, 1, 32'h7, 8'h11,   0, 1, 0, 0, 0);
    cyc("post_wr",     0, 0, 0, 1, 32'h7, 8'h11,   0, 0, 17'h7, 1, 8'h11);
    cyc("post_drop",   0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected observations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
